// File: rtl/alu16_sequencer.sv
// 16-bit ALU sequencer: runs one request as four 4-bit slices through an external
// combinational ALU, chaining the carry, and returns a registered 16-bit response.
module alu16_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   input  logic [2:0]  req_op,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_result,
   output logic        resp_zero,
   output logic        resp_cout,
   output logic        resp_ovf,
   output logic        resp_err,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   output logic [2:0]  alu_control,
   output logic        alu_cin,
   input  logic [3:0]  alu_result,
   input  logic        alu_zero,
   input  logic        alu_cout
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        carry_q, carry_d;
   logic [11:0] part_q, part_d;
   logic        zacc_q, zacc_d;
   logic [15:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic        cout_q, cout_d;
   logic        ovf_q, ovf_d;
   logic        err_q, err_d;

   logic is_add, is_sub, is_arith, ovf_final;

   assign is_add   = (op_q == OP_ADD);
   assign is_sub   = (op_q == OP_SUB);
   assign is_arith = is_add | is_sub;

   // alu_result[3] is result bit 15 while the top nibble is being issued
   assign ovf_final = (is_add && (a_q[15] == b_q[15]) && (alu_result[3] != a_q[15])) ||
                      (is_sub && (a_q[15] != b_q[15]) && (alu_result[3] != a_q[15]));

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      part_d      = part_q;
      zacc_d      = zacc_q;
      result_d    = result_q;
      zero_d      = zero_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      err_d       = err_q;
      alu_a       = 4'd0;
      alu_b       = 4'd0;
      alu_control = 3'd0;
      alu_cin     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               op_d    = req_op;
               cnt_d   = 2'd0;
               carry_d = 1'b0;
               zacc_d  = 1'b1;
               if (req_op[2:1] == 2'b11) begin
                  state_d  = DONE;
                  result_d = 16'd0;
                  zero_d   = 1'b1;
                  cout_d   = 1'b0;
                  ovf_d    = 1'b0;
                  err_d    = 1'b1;
               end else begin
                  state_d = ISSUE;
               end
            end
         end

         ISSUE: begin
            alu_a       = a_q[{cnt_q, 2'b00} +: 4];
            alu_b       = b_q[{cnt_q, 2'b00} +: 4];
            alu_control = op_q;
            alu_cin     = (cnt_q == 2'd0) ? is_sub : (is_arith & carry_q);
            carry_d     = alu_cout;
            zacc_d      = zacc_q & alu_zero;
            cnt_d       = cnt_q + 2'd1;
            case (cnt_q)
               2'd0: part_d[3:0]  = alu_result;
               2'd1: part_d[7:4]  = alu_result;
               2'd2: part_d[11:8] = alu_result;
               default: begin
                  state_d  = DONE;
                  result_d = {alu_result, part_q};
                  zero_d   = zacc_q & alu_zero;
                  cout_d   = is_arith & alu_cout;
                  ovf_d    = ovf_final;
                  err_d    = 1'b0;
               end
            endcase
         end

         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= 16'd0;
         b_q      <= 16'd0;
         op_q     <= 3'd0;
         cnt_q    <= 2'd0;
         carry_q  <= 1'b0;
         part_q   <= 12'd0;
         zacc_q   <= 1'b0;
         result_q <= 16'd0;
         zero_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         part_q   <= part_d;
         zacc_q   <= zacc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign resp_valid  = (state_q == DONE);
   assign resp_result = result_q;
   assign resp_zero   = zero_q;
   assign resp_cout   = cout_q;
   assign resp_ovf    = ovf_q;
   assign resp_err    = err_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Randomized self-checking bench for alu16_sequencer with a behavioural 4-bit ALU
// and a 16-bit arithmetic reference model.
module tb_alu16_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [15:0] req_a, req_b;
   logic [2:0]  req_op;
   logic        resp_valid, resp_ready;
   logic [15:0] resp_result;
   logic        resp_zero, resp_cout, resp_ovf, resp_err;
   logic [3:0]  alu_a, alu_b, alu_result;
   logic [2:0]  alu_control;
   logic        alu_cin, alu_zero, alu_cout;
   logic [4:0]  alu_sum;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu16_sequencer dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_zero(resp_zero), .resp_cout(resp_cout),
      .resp_ovf(resp_ovf), .resp_err(resp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout)
   );

   // external 4-bit combinational ALU
   always_comb begin
      alu_sum = 5'd0;
      case (alu_control)
         3'd0: alu_sum = {1'b0, alu_a & alu_b};
         3'd1: alu_sum = {1'b0, alu_a | alu_b};
         3'd2: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
         3'd3: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
         3'd4: alu_sum = {1'b0, alu_a ^ alu_b};
         3'd5: alu_sum = {1'b0, ~(alu_a | alu_b)};
         default: alu_sum = 5'd0;
      endcase
   end
   assign alu_result = alu_sum[3:0];
   assign alu_cout   = (alu_control == 3'd2 || alu_control == 3'd3) ? alu_sum[4] : 1'b0;
   assign alu_zero   = (alu_result == 4'd0);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                                 output logic [15:0] r, output logic z, output logic c,
                                 output logic v, output logic e, output logic [3:0] cins);
      logic [16:0] s;
      logic [15:0] bb;
      int mask, part, cin0;
      r = 16'd0; c = 1'b0; v = 1'b0; e = 1'b0; cins = 4'd0;
      bb = (op == 3'd3) ? ~b : b;
      cin0 = (op == 3'd3) ? 1 : 0;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
         3'd3: begin s = {1'b0, a} + {1'b0, bb} + 17'd1; r = s[15:0]; c = s[16]; end
         3'd4: r = a ^ b;
         3'd5: r = ~(a | b);
         default: e = 1'b1;
      endcase
      z = (r == 16'd0);
      if (op == 3'd2) v = (a[15] == b[15]) && (r[15] != a[15]);
      if (op == 3'd3) v = (a[15] != b[15]) && (r[15] != a[15]);
      if (op == 3'd2 || op == 3'd3) begin
         for (int k = 0; k < 4; k++) begin
            mask = (1 << (4 * k)) - 1;
            part = (int'(a) & mask) + (int'(bb) & mask) + cin0;
            cins[k] = (k == 0) ? cin0[0] : part[4 * k];
         end
      end
   endfunction

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input int hold);
      logic [15:0] er, ga, gb;
      logic        ez, ec, ev, ee, ctl_bad;
      logic [3:0]  ecin, gcin;
      int lat, n;
      model(a, b, op, er, ez, ec, ev, ee, ecin);
      req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      check("req_ready_wait", 32'(n < 50), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom); req_op = 3'($urandom);
      lat = 1; ga = 16'd0; gb = 16'd0; gcin = 4'd0; ctl_bad = 1'b0;
      while (!resp_valid && lat < 20) begin
         if (lat <= 4) begin
            ga[4 * (lat - 1) +: 4] = alu_a;
            gb[4 * (lat - 1) +: 4] = alu_b;
            gcin[lat - 1] = alu_cin;
            if (alu_control !== op) ctl_bad = 1'b1;
         end
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), ee ? 32'd1 : 32'd5);
      check("result", 32'(resp_result), 32'(er));
      check("flags", {28'd0, resp_zero, resp_cout, resp_ovf, resp_err}, {28'd0, ez, ec, ev, ee});
      check("alu_idle_done", {17'd0, alu_a, alu_b, alu_control, alu_cin}, 32'd0);
      if (!ee) begin
         check("alu_a_seq", 32'(ga), 32'(a));
         check("alu_b_seq", 32'(gb), 32'(b));
         check("alu_cin_seq", 32'(gcin), 32'(ecin));
         check("alu_ctl", 32'(ctl_bad), 32'd0);
      end
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_a = 16'($urandom); req_op = 3'd2;
         @(negedge clk);
         check("hold_stable", {10'd0, resp_valid, req_ready, resp_result, resp_zero, resp_cout, resp_ovf, resp_err},
               {10'd0, 1'b1, 1'b0, er, ez, ec, ev, ee});
      end
      req_valid = 1'b1;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid = 1'b0;
      check("post_done", {30'd0, resp_valid, req_ready}, 32'd1);
      $display("txn op=%0d a=%h b=%h -> res=%h z=%0d c=%0d v=%0d e=%0d lat=%0d", op, a, b,
               resp_result, resp_zero, resp_cout, resp_ovf, resp_err, lat);
   endtask

   initial begin
      int hsk;
      logic rv_seen;
      reset = 1'b1; req_valid = 1'b0; req_a = 16'd0; req_b = 16'd0; req_op = 3'd0; resp_ready = 1'b0;
      #1;
      check("reset_outs", {10'd0, resp_valid, resp_result, resp_zero, resp_cout, resp_ovf, resp_err}, 32'd0);
      check("reset_alu", {17'd0, alu_a, alu_b, alu_control, alu_cin}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 32'(req_ready), 32'd1);

      do_op(16'h00FF, 16'h0001, 3'd2, 0);
      do_op(16'h8000, 16'h0001, 3'd3, 0);
      do_op(16'h1234, 16'h1234, 3'd3, 1);
      do_op(16'hFFFF, 16'h0001, 3'd2, 0);
      do_op(16'hA5A5, 16'h5A5A, 3'd4, 0);
      do_op(16'h1357, 16'h2468, 3'd6, 0);
      do_op(16'hBEEF, 16'hF00D, 3'd7, 2);
      do_op(16'h7FFF, 16'h0001, 3'd2, 10);

      // reset while the third nibble is on the ALU
      req_a = 16'h0F00; req_b = 16'h0100; req_op = 3'd2; req_valid = 1'b1;
      hsk = 0;
      while (!req_ready && hsk < 50) begin @(negedge clk); hsk++; end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_issue_nibble", {24'd0, alu_a, alu_b}, {24'd0, 4'hF, 4'h1});
      reset = 1'b1;
      #1;
      check("abort_state", {28'd0, req_ready, resp_valid, alu_cin, 1'b0}, {28'd0, 4'b1000});
      check("abort_alu", {17'd0, alu_a, alu_b, alu_control, alu_cin}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      rv_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp_valid) rv_seen = 1'b1;
      end
      check("no_resp_after_abort", 32'(rv_seen), 32'd0);
      do_op(16'h0003, 16'h0004, 3'd2, 0);
      check("post_abort_result", 32'(resp_result), 32'h0007);

      for (int t = 0; t < 40; t++) begin
         do_op(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
